jtsdram_arb: RTL
================

Name: jtsdram_arb

Overview:
- Round-robin arbiter sharing the single SDRAM programming/access port among four bank-owning requesters.
- Requester i always targets bank i.
- Typical use: per-bank pattern writers and readers in the memory test.
- Sits between the requesters and the SDRAM controller port (addr/data/ba/we/rd/ack/rdy). It also inserts host refresh windows (e.g. during vertical blank).

Parameters:
- AW, 22, word address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req  in  4  request per requester; held high until its rdy pulse
- req_we  in  4  1=write, 0=read, per requester
- req_addr  in  4*AW  addresses; requester i at [i*AW +: AW]
- req_din  in  4*DW  write data; requester i at [i*DW +: DW]
- req_mask  in  8  byte masks; requester i at [2i +: 2]
- gnt  out  4  one-hot owner of the port; 0 when idle or refreshing
- ack  out  4  one-cycle pulse to owner when the controller accepts the command
- rdy  out  4  one-cycle pulse to owner when the access completes
- dout  out  DW  read data, valid with rdy
- rfsh_req  in  1  request for a refresh window
- rfsh_busy  out  1  high while in RFSH
- xfer_cnt  out  16  completed-transaction counter
- sd_addr  out  AW  controller address
- sd_ba  out  2  bank (= owner index)
- sd_din  out  DW  write data
- sd_mask  out  2  byte mask
- sd_we  out  1  write strobe
- sd_rd  out  1  read strobe
- sd_ack  in  1  command accepted
- sd_rdy  in  1  access complete
- sd_dout  in  DW  read data
- sd_rfsh  out  1  refresh enable to controller

Behaviour:
- Reset: every output 0; state IDLE; round-robin pointer last=3, so requester 0 has top priority first.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RFSH.
- IDLE, priority order:
  - rfsh_req=1 → RFSH next cycle. Refresh beats requesters, but only from IDLE; it never preempts a transaction.
  - Otherwise, if any req is set: winner = first set bit scanning last+1, last+2, … modulo 4.
  - Next cycle: gnt=onehot(winner); sd_addr/sd_din/sd_mask/sd_ba latched from the winner; sd_we=req_we[w]; sd_rd=~req_we[w]; last<=w; go to ISSUE.
  - Grant latency: 1 cycle from req seen in IDLE.
- ISSUE:
  - On sd_ack: sd_we and sd_rd drop the next cycle; ack[w] pulses the next cycle.
  - If sd_rdy is not also high, go to WAIT.
  - If sd_ack and sd_rdy arrive in the same cycle, take the WAIT completion actions directly; ack and rdy pulse together.
- WAIT:
  - On sd_rdy, next cycle: rdy[w]=1 for one cycle; dout<=sd_dout (sampled on reads, held on writes); gnt=0; xfer_cnt+1, wrapping 0xFFFF→0; go to IDLE.
  - sd_rdy seen while still in ISSUE without sd_ack is ignored.
- Back-to-back: minimum IDLE dwell is 1 cycle between transactions. A continuously requesting owner yields to any other pending requester.
- Request/data stability:
  - Dropping req[w] mid-transaction does not abort; the access completes and rdy still pulses.
  - Changes to the owner's addr/din after the grant are ignored.
- RFSH: sd_rfsh=1 and rfsh_busy=1 while rfsh_req stays high. When rfsh_req falls, both clear next cycle and the FSM returns to IDLE. Requests are held off, not lost.
- Asynchronous rst mid-transaction: immediate return to reset values. The controller is expected to be reset alongside the arbiter.

Decomposition:
- Shared package jtsdram_pkg: FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RFSH=3) and the requester count constant NREQ=4.
- One sub-module: jtsdram_rr4, combinational round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: winner[1:0], any.

Test Plan:
- Single write: req=0001, we=1, addr=0x12345, din=0xA5A5. → gnt=0001 one cycle later; sd_ba=0, sd_we=1; after sd_ack, ack[0] pulses; after sd_rdy, rdy[0] pulses and xfer_cnt=1.
- Contention: req=1111 held continuously with 2-cycle ack/rdy. → grant order 0,1,2,3,0; sd_ba follows 0,1,2,3,0.
- Read data: req[2] read, controller returns sd_dout=0xBEEF with sd_rdy. → rdy[2]=1 and dout=0xBEEF in the same cycle; sd_rd low after ack.
- Refresh: rfsh_req raised during a WAIT on requester 1. → the transaction completes first, then sd_rfsh=1 while req[3] is pending. When rfsh_req falls, req[3] is granted within 2 cycles.
- Same-cycle ack+rdy on requester 3. → ack[3] and rdy[3] pulse together; FSM back in IDLE; next request granted the following cycle.
- Reset: rst asserted during ISSUE with sd_we=1. → sd_we, gnt, xfer_cnt all 0 immediately; after release, req=1000 → grant goes to requester 3 (the pointer reset to 3 so requester 0 would win first, but only 3 requests).

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding,
// requester count and a one-hot helper.
package jtsdram_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RFSH  = 2'd3
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/jtsdram_rr4.sv
// Combinational round-robin picker for four requesters. The search starts
// at the requester after `last` and wraps modulo 4, so the previous owner
// has the lowest priority.
module jtsdram_rr4
  import jtsdram_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      winner,
  output logic            any
);

  logic [1:0] cand;

  // Scan from the farthest candidate down to the nearest so the nearest set bit wins.
  always_comb begin
    winner = last;
    cand   = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        winner = cand;
      end else begin
        winner = winner;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/jtsdram_arb.sv
// Round-robin arbiter sharing one SDRAM controller port among four
// bank-owning requesters (requester i always uses bank i), with host
// refresh windows inserted between transactions. All outputs registered.
module jtsdram_arb
  import jtsdram_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [3:0]        req_we,
  input  logic [4*AW-1:0]   req_addr,
  input  logic [4*DW-1:0]   req_din,
  input  logic [7:0]        req_mask,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic [3:0]        rdy,
  output logic [DW-1:0]     dout,
  input  logic              rfsh_req,
  output logic              rfsh_busy,
  output logic [15:0]       xfer_cnt,
  output logic [AW-1:0]     sd_addr,
  output logic [1:0]        sd_ba,
  output logic [DW-1:0]     sd_din,
  output logic [1:0]        sd_mask,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic              sd_ack,
  input  logic              sd_rdy,
  input  logic [DW-1:0]     sd_dout,
  output logic              sd_rfsh
);

  arb_state_e      state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic            we_q, we_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [3:0]      ack_q, ack_d;
  logic [3:0]      rdy_q, rdy_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            rfsh_busy_q, rfsh_busy_d;
  logic            sd_rfsh_q, sd_rfsh_d;
  logic [15:0]     xfer_cnt_q, xfer_cnt_d;
  logic [AW-1:0]   sd_addr_q, sd_addr_d;
  logic [1:0]      sd_ba_q, sd_ba_d;
  logic [DW-1:0]   sd_din_q, sd_din_d;
  logic [1:0]      sd_mask_q, sd_mask_d;
  logic            sd_we_q, sd_we_d;
  logic            sd_rd_q, sd_rd_d;

  logic [1:0]      winner;
  logic            any_req;
  logic            done;

  jtsdram_rr4 u_rr4 (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // Next-state and output computation for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    we_d        = we_q;
    gnt_d       = gnt_q;
    ack_d       = 4'b0000;
    rdy_d       = 4'b0000;
    dout_d      = dout_q;
    rfsh_busy_d = 1'b0;
    sd_rfsh_d   = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;
    sd_addr_d   = sd_addr_q;
    sd_ba_d     = sd_ba_q;
    sd_din_d    = sd_din_q;
    sd_mask_d   = sd_mask_q;
    sd_we_d     = sd_we_q;
    sd_rd_d     = sd_rd_q;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Refresh wins over requesters, but only between transactions.
        if (rfsh_req) begin
          state_d     = ST_RFSH;
          rfsh_busy_d = 1'b1;
          sd_rfsh_d   = 1'b1;
        end else if (any_req) begin
          state_d   = ST_ISSUE;
          last_d    = winner;
          gnt_d     = onehot4(winner);
          we_d      = req_we[winner];
          sd_we_d   = req_we[winner];
          sd_rd_d   = ~req_we[winner];
          sd_ba_d   = winner;
          sd_addr_d = req_addr[winner*AW +: AW];
          sd_din_d  = req_din[winner*DW +: DW];
          sd_mask_d = req_mask[winner*2 +: 2];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A completion without acceptance is meaningless here and is ignored.
        if (sd_ack) begin
          sd_we_d = 1'b0;
          sd_rd_d = 1'b0;
          ack_d   = gnt_q;
          if (sd_rdy) begin
            done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (sd_rdy) begin
          done = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RFSH: begin
        if (rfsh_req) begin
          rfsh_busy_d = 1'b1;
          sd_rfsh_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion: pulse rdy, capture read data, release the port.
    if (done) begin
      rdy_d      = gnt_q;
      dout_d     = we_q ? dout_q : sd_dout;
      gnt_d      = 4'b0000;
      xfer_cnt_d = xfer_cnt_q + 16'd1;
      state_d    = ST_IDLE;
    end else begin
      rdy_d = 4'b0000;
    end
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd3;
      we_q        <= 1'b0;
      gnt_q       <= 4'b0000;
      ack_q       <= 4'b0000;
      rdy_q       <= 4'b0000;
      dout_q      <= '0;
      rfsh_busy_q <= 1'b0;
      sd_rfsh_q   <= 1'b0;
      xfer_cnt_q  <= 16'd0;
      sd_addr_q   <= '0;
      sd_ba_q     <= 2'd0;
      sd_din_q    <= '0;
      sd_mask_q   <= 2'd0;
      sd_we_q     <= 1'b0;
      sd_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      rfsh_busy_q <= rfsh_busy_d;
      sd_rfsh_q   <= sd_rfsh_d;
      xfer_cnt_q  <= xfer_cnt_d;
      sd_addr_q   <= sd_addr_d;
      sd_ba_q     <= sd_ba_d;
      sd_din_q    <= sd_din_d;
      sd_mask_q   <= sd_mask_d;
      sd_we_q     <= sd_we_d;
      sd_rd_q     <= sd_rd_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdy       = rdy_q;
  assign dout      = dout_q;
  assign rfsh_busy = rfsh_busy_q;
  assign sd_rfsh   = sd_rfsh_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign sd_addr   = sd_addr_q;
  assign sd_ba     = sd_ba_q;
  assign sd_din    = sd_din_q;
  assign sd_mask   = sd_mask_q;
  assign sd_we     = sd_we_q;
  assign sd_rd     = sd_rd_q;

endmodule
